// File: rtl/queue_cntrl_occ.sv
// queue_cntrl_occ: pointer/occupancy controller for an external N-entry RAM.
// Handles any depth N >= 2, rejects illegal push/pop, tracks occupancy with
// programmable almost-full/almost-empty thresholds, supports a synchronous
// flush, and keeps sticky overflow/underflow flags.
//
// Handshake: a push is accepted (o_wr_en=1, data written at o_wr_addr) in the
// same cycle it is requested when the queue is not full, or when it is full
// and a pop is accepted alongside it. A pop is accepted (o_rd_en=1, entry at
// o_rd_addr consumed) whenever the queue is not empty; there is no
// write-to-read bypass. Flush and reset suppress both strobes. Rejected
// requests are not retried here; they only raise the sticky error flags.
module queue_cntrl_occ #(
    parameter int N      = 4,
    parameter int ADDR_W = $clog2(N),
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic              i_clr_err,
    input  logic [CNT_W-1:0]  i_af_thresh,
    input  logic [CNT_W-1:0]  i_ae_thresh,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [CNT_W-1:0]  o_count_r,
    output logic              o_full_r,
    output logic              o_empty_r,
    output logic              o_almost_full_r,
    output logic              o_almost_empty_r,
    output logic              o_overflow_r,
    output logic              o_underflow_r
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(N);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_acc, pop_acc;
    logic              push_rej, pop_rej;

    // Accept decisions; a full queue can take a push only with a pop that frees a slot.
    always_comb begin
        push_acc = 1'b0;
        pop_acc  = 1'b0;
        push_rej = 1'b0;
        pop_rej  = 1'b0;
        if (!rst && !i_flush) begin
            pop_acc  = i_pop & ~empty_q;
            push_acc = i_push & (~full_q | i_pop);
            push_rej = i_push & ~push_acc;
            pop_rej  = i_pop & ~pop_acc;
        end
    end

    // Next pointers, occupancy and registered flags derived from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop_acc)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        end
        full_d   = (count_d == FULL_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= i_af_thresh);
        aempty_d = (count_d <= i_ae_thresh);
        // A new rejection in the same cycle as a clear keeps the flag set.
        ovf_d    = push_rej | (ovf_q & ~i_clr_err);
        unf_d    = pop_rej  | (unf_q & ~i_clr_err);
    end

    // State register; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign o_wr_en          = push_acc;
    assign o_rd_en          = pop_acc;
    assign o_wr_addr        = wr_ptr_q;
    assign o_rd_addr        = rd_ptr_q;
    assign o_count_r        = count_q;
    assign o_full_r         = full_q;
    assign o_empty_r        = empty_q;
    assign o_almost_full_r  = afull_q;
    assign o_almost_empty_r = aempty_q;
    assign o_overflow_r     = ovf_q;
    assign o_underflow_r    = unf_q;

endmodule
